motor_plant: RTL and testbench
==============================

Name: motor_plant

Overview:
- Behavioural/synthesizable plant model of the motorized door driven by the motor controller.
- Consumes the controller's motor_up/motor_dn commands.
- Integrates travel into a position counter and generates the up_limit/dn_limit switches the controller waits on.
- Flags illegal drive: both directions at once, or driving into a limit for too long.
- Used as the closed-loop counterpart in system benches and on FPGA demo builds.

Parameters:
- PW, 8, width of position counter.
- TRAVEL, 16, position value at the top limit; bottom limit is 0. Legal range: 1 <= TRAVEL <= 2**PW-1.
- STEP_DIV, 1, clock cycles per one position step while moving; must be >= 1.
- INIT_POS, 0, position loaded at reset; must be <= TRAVEL.
- OVERRUN_MAX, 4, consecutive cycles the motor may push against an active limit before an overrun fault; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- motor_up  in  1  drive upward command.
- motor_dn  in  1  drive downward command.
- fault_clr  in  1  single-cycle request to leave FAULT.
- up_limit  out  1  high when position == TRAVEL.
- dn_limit  out  1  high when position == 0.
- position  out  PW  current position, 0..TRAVEL.
- moving  out  1  high in RISING or FALLING.
- fault  out  1  high in FAULT.
- fault_code  out  2  0 none, 1 conflict (both commands high), 2 overrun.

Behaviour:
- Reset values (immediate, asynchronous):
  - state=IDLE, position=INIT_POS, moving=0, fault=0, fault_code=0.
  - Prescaler div_cnt=0, overrun counter ovr_cnt=0.
  - up_limit/dn_limit are decoded from INIT_POS.
- up_limit/dn_limit are pure decodes of the position register. They are glitch-free and change only on the edge where position changes. TRAVEL>=1 guarantees both are never high together.
- FSM states: IDLE, RISING, FALLING, FAULT.
- Conflict has top priority: if motor_up&motor_dn is sampled high in any non-FAULT state, go to FAULT with fault_code=1. Position and div_cnt are frozen.
- IDLE:
  - motor_up only and position<TRAVEL -> RISING.
  - motor_dn only and position>0 -> FALLING.
  - Entering RISING or FALLING sets div_cnt=0.
- RISING/FALLING:
  - div_cnt increments each cycle. When div_cnt==STEP_DIV-1, position steps ±1 and div_cnt returns to 0.
  - If the step reaches TRAVEL (RISING) or 0 (FALLING), go to IDLE on that same edge: the limit asserts and moving deasserts together.
  - If the active command is sampled low, go to IDLE and hold position; any partial div_cnt is discarded.
  - If the opposite command alone is sampled high, go directly to IDLE. No reversal in one cycle; reversal takes effect on the next edge.
- Full travel timing: 0 to TRAVEL takes exactly TRAVEL*STEP_DIV cycles after entering RISING. FALLING is symmetric.
- Overrun detection:
  - In IDLE, while (motor_up & up_limit) or (motor_dn & dn_limit), ovr_cnt increments.
  - On the edge where it would reach OVERRUN_MAX -> FAULT, fault_code=2.
  - Any cycle without such drive clears ovr_cnt. ovr_cnt also clears on leaving IDLE.
- FAULT:
  - position is held, moving=0, fault=1.
  - Exits to IDLE only when fault_clr=1 and motor_up=motor_dn=0 in the same cycle; that exit clears fault_code and ovr_cnt.
  - fault_clr outside FAULT is ignored.
- Widths: position arithmetic is PW bits. No wrap is possible because stepping is blocked at 0 and TRAVEL.
- Reset asserted mid-motion aborts immediately to reset values. No step completes on the reset-release edge.

Test Plan:
- Reset, INIT_POS=0, STEP_DIV=2, TRAVEL=16:
  - Check dn_limit=1, up_limit=0, position=0.
  - Hold motor_up -> moving=1 one edge later; dn_limit drops after 2 cycles; position=16 and up_limit=1, moving=0 exactly 32 cycles after entering RISING.
- At top, hold motor_up 3 cycles then drop -> no fault. Hold it 4 cycles -> fault=1, fault_code=2. Pulse fault_clr with motor_up still high -> stays FAULT; repeat with inputs low -> IDLE, fault_code=0.
- Mid-travel at position 5, raise motor_dn with motor_up -> FAULT code 1 next edge, position frozen at 5.
- STEP_DIV=3, moving up from 0: drop motor_up after 7 cycles -> position=2, partial count discarded; re-raise -> next step after full 3 cycles.
- Moving up at position 8: switch to motor_dn only -> one IDLE cycle, then FALLING; reaches 0 with dn_limit=1 after 8*STEP_DIV further cycles.
- Assert rst asynchronously mid-step at position 9 -> outputs return instantly to position=INIT_POS, moving=0, fault=0; no motion on the release edge.

Source files
------------

// File: rtl/motor_plant.sv
// Plant model of the motorized door driven by the motor controller.
// Integrates motor_up/motor_dn drive into a bounded position counter, decodes
// the travel limit switches from that position, and latches a fault on
// illegal drive (both directions at once, or pushing into a limit too long).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   motor_up   drive upward command
//   motor_dn   drive downward command
//   fault_clr  single-cycle request to leave FAULT (needs both commands low)
//   up_limit   high when position == TRAVEL
//   dn_limit   high when position == 0
//   position   current position, 0..TRAVEL
//   moving     high while rising or falling
//   fault      high while in FAULT
//   fault_code 0 none, 1 conflicting commands, 2 limit overrun
module motor_plant #(
  parameter int unsigned PW          = 8,
  parameter int unsigned TRAVEL      = 16,
  parameter int unsigned STEP_DIV    = 1,
  parameter int unsigned INIT_POS    = 0,
  parameter int unsigned OVERRUN_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          motor_up,
  input  logic          motor_dn,
  input  logic          fault_clr,
  output logic          up_limit,
  output logic          dn_limit,
  output logic [PW-1:0] position,
  output logic          moving,
  output logic          fault,
  output logic [1:0]    fault_code
);

  // Counters are sized to hold at most STEP_DIV-1 / OVERRUN_MAX-1; keep >= 1 bit.
  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned OW = (OVERRUN_MAX > 1) ? $clog2(OVERRUN_MAX) : 1;

  localparam logic [PW-1:0] PosTop  = PW'(TRAVEL);
  localparam logic [PW-1:0] PosInit = PW'(INIT_POS);
  localparam logic [DW-1:0] DivLast = DW'(STEP_DIV - 1);
  localparam logic [OW-1:0] OvrLast = OW'(OVERRUN_MAX - 1);

  localparam logic [1:0] CodeNone     = 2'd0;
  localparam logic [1:0] CodeConflict = 2'd1;
  localparam logic [1:0] CodeOverrun  = 2'd2;

  typedef enum logic [1:0] {StIdle, StRising, StFalling, StFault} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [DW-1:0] div_q, div_d;
  logic [OW-1:0] ovr_q, ovr_d;
  logic [1:0]    code_q, code_d;

  logic          conflict;
  logic          at_top;
  logic          at_bot;
  logic          push_limit;
  logic [PW-1:0] pos_inc;
  logic [PW-1:0] pos_dec;

  assign conflict   = motor_up & motor_dn;
  assign at_top     = (pos_q == PosTop);
  assign at_bot     = (pos_q == '0);
  assign push_limit = (motor_up & at_top) | (motor_dn & at_bot);
  assign pos_inc    = pos_q + 1'b1;
  assign pos_dec    = pos_q - 1'b1;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    div_d   = div_q;
    ovr_d   = ovr_q;
    code_d  = code_q;

    unique case (state_q)
      StIdle: begin
        if (conflict) begin
          state_d = StFault;
          code_d  = CodeConflict;
          ovr_d   = '0;
        end else if (push_limit) begin
          if (ovr_q == OvrLast) begin
            state_d = StFault;
            code_d  = CodeOverrun;
            ovr_d   = '0;
          end else begin
            ovr_d = ovr_q + 1'b1;
          end
        end else begin
          ovr_d = '0;
          if (motor_up && !at_top) begin
            state_d = StRising;
            div_d   = '0;
          end else if (motor_dn && !at_bot) begin
            state_d = StFalling;
            div_d   = '0;
          end
        end
      end

      StRising: begin
        if (conflict) begin
          // Position and prescaler freeze where they are.
          state_d = StFault;
          code_d  = CodeConflict;
        end else if (!motor_up) begin
          // Covers both release and reversal request; reversal starts next edge.
          state_d = StIdle;
          div_d   = '0;
        end else if (div_q == DivLast) begin
          div_d = '0;
          pos_d = pos_inc;
          if (pos_inc == PosTop) state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StFalling: begin
        if (conflict) begin
          state_d = StFault;
          code_d  = CodeConflict;
        end else if (!motor_dn) begin
          state_d = StIdle;
          div_d   = '0;
        end else if (div_q == DivLast) begin
          div_d = '0;
          pos_d = pos_dec;
          if (pos_dec == '0) state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StFault: begin
        if (fault_clr && !motor_up && !motor_dn) begin
          state_d = StIdle;
          code_d  = CodeNone;
          ovr_d   = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pos_q   <= PosInit;
      div_q   <= '0;
      ovr_q   <= '0;
      code_q  <= CodeNone;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      ovr_q   <= ovr_d;
      code_q  <= code_d;
    end
  end

  // Limits decode straight from the position register, so they move only on
  // the edge where position changes.
  assign up_limit   = at_top;
  assign dn_limit   = at_bot;
  assign position   = pos_q;
  assign moving     = (state_q == StRising) || (state_q == StFalling);
  assign fault      = (state_q == StFault);
  assign fault_code = code_q;

endmodule

// File: tb/tb_motor_plant.sv
// Bench for motor_plant: two instances (STEP_DIV=2 and STEP_DIV=3) share
// stimulus; a behavioural plant model is checked against both on every
// falling edge, and directed scenarios add hand-computed literal checks.
module tb_motor_plant;

  localparam int unsigned PW   = 8;
  localparam int          TRV  = 16;
  localparam int          OVR  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic motor_up = 1'b0;
  logic motor_dn = 1'b0;
  logic fault_clr = 1'b0;

  logic          a_up_limit, a_dn_limit, a_moving, a_fault;
  logic [PW-1:0] a_position;
  logic [1:0]    a_fault_code;
  logic          b_up_limit, b_dn_limit, b_moving, b_fault;
  logic [PW-1:0] b_position;
  logic [1:0]    b_fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  motor_plant #(
    .PW(PW), .TRAVEL(TRV), .STEP_DIV(2), .INIT_POS(0), .OVERRUN_MAX(OVR)
  ) dut_a (
    .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
    .fault_clr(fault_clr), .up_limit(a_up_limit), .dn_limit(a_dn_limit),
    .position(a_position), .moving(a_moving), .fault(a_fault), .fault_code(a_fault_code)
  );

  motor_plant #(
    .PW(PW), .TRAVEL(TRV), .STEP_DIV(3), .INIT_POS(0), .OVERRUN_MAX(OVR)
  ) dut_b (
    .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
    .fault_clr(fault_clr), .up_limit(b_up_limit), .dn_limit(b_dn_limit),
    .position(b_position), .moving(b_moving), .fault(b_fault), .fault_code(b_fault_code)
  );

  // Behavioural model. mode: 0 idle, 1 moving up, 2 moving down, 3 fault.
  int m_mode[2];
  int m_pos[2];
  int m_tick[2];
  int m_push[2];
  int m_code[2];

  function automatic int step_div(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_pos[i] = 0; m_tick[i] = 0; m_push[i] = 0; m_code[i] = 0;
      end else if (m_mode[i] == 3) begin
        if (fault_clr && !motor_up && !motor_dn) begin
          m_mode[i] = 0; m_code[i] = 0; m_push[i] = 0;
        end
      end else if (motor_up && motor_dn) begin
        m_mode[i] = 3; m_code[i] = 1; m_push[i] = 0;
      end else if (m_mode[i] == 0) begin
        if ((motor_up && m_pos[i] == TRV) || (motor_dn && m_pos[i] == 0)) begin
          m_push[i] = m_push[i] + 1;
          if (m_push[i] == OVR) begin
            m_mode[i] = 3; m_code[i] = 2; m_push[i] = 0;
          end
        end else begin
          m_push[i] = 0;
          if (motor_up && m_pos[i] < TRV) begin
            m_mode[i] = 1; m_tick[i] = 0;
          end else if (motor_dn && m_pos[i] > 0) begin
            m_mode[i] = 2; m_tick[i] = 0;
          end
        end
      end else begin
        if (!((m_mode[i] == 1) ? motor_up : motor_dn)) begin
          m_mode[i] = 0;
        end else begin
          m_tick[i] = m_tick[i] + 1;
          if (m_tick[i] == step_div(i)) begin
            m_tick[i] = 0;
            m_pos[i] = m_pos[i] + ((m_mode[i] == 1) ? 1 : -1);
            if (m_pos[i] == 0 || m_pos[i] == TRV) m_mode[i] = 0;
          end
        end
      end
    end
  end

  function automatic logic [13:0] model_vec(input int i);
    logic [PW-1:0] p;
    logic [1:0]    c;
    p = PW'(m_pos[i]);
    c = 2'(m_code[i]);
    return {m_pos[i] == TRV, m_pos[i] == 0, p, m_mode[i] == 1 || m_mode[i] == 2,
            m_mode[i] == 3, c};
  endfunction

  logic [13:0] got[2];
  assign got[0] = {a_up_limit, a_dn_limit, a_position, a_moving, a_fault, a_fault_code};
  assign got[1] = {b_up_limit, b_dn_limit, b_position, b_moving, b_fault, b_fault_code};

  // Vector layout: {up_limit, dn_limit, position[7:0], moving, fault, fault_code[1:0]}
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [13:0] exp_v;
      exp_v = model_vec(i);
      n_cmp++;
      if (got[i] !== exp_v) begin
        n_bad++;
        $display("FAIL model_dut%0d t=%0t got=%h expected=%h", i, $time, got[i], exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick(1);

    // Reset state, STEP_DIV=2
    chk("rst_dn_limit", a_dn_limit, 1);
    chk("rst_up_limit", a_up_limit, 0);
    chk("rst_position", a_position, 0);
    chk("rst_fault", a_fault, 0);

    // Full upward travel
    motor_up = 1'b1;
    tick(1);
    chk("rise_moving", a_moving, 1);
    chk("rise_pos0", a_position, 0);
    tick(1);
    chk("rise_dn_still", a_dn_limit, 1);
    tick(1);
    chk("rise_dn_drop", a_dn_limit, 0);
    chk("rise_pos1", a_position, 1);
    tick(29);
    chk("rise_pos15", a_position, 15);
    chk("rise_moving15", a_moving, 1);
    tick(1);
    chk("top_pos", a_position, 16);
    chk("top_up_limit", a_up_limit, 1);
    chk("top_moving", a_moving, 0);

    // Push into top limit: 3 cycles tolerated, 4 faults
    tick(3);
    chk("ovr3_fault", a_fault, 0);
    motor_up = 1'b0;
    tick(1);
    motor_up = 1'b1;
    tick(3);
    chk("ovr3b_fault", a_fault, 0);
    tick(1);
    chk("ovr4_fault", a_fault, 1);
    chk("ovr4_code", a_fault_code, 2);
    chk("ovr4_pos", a_position, 16);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_held_fault", a_fault, 1);
    motor_up = 1'b0;
    tick(1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_fault", a_fault, 0);
    chk("clr_code", a_fault_code, 0);

    // Down to 5, then conflict
    motor_dn = 1'b1;
    tick(23);
    chk("fall_pos5", a_position, 5);
    chk("fall_moving5", a_moving, 1);
    motor_up = 1'b1;
    tick(1);
    chk("conf_fault", a_fault, 1);
    chk("conf_code", a_fault_code, 1);
    chk("conf_pos", a_position, 5);
    tick(2);
    chk("conf_frozen", a_position, 5);
    motor_up = 1'b0;
    motor_dn = 1'b0;
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("conf_clr", a_fault, 0);

    // Reversal at 8
    motor_up = 1'b1;
    tick(7);
    chk("rev_pos8", a_position, 8);
    motor_up = 1'b0;
    motor_dn = 1'b1;
    tick(1);
    chk("rev_idle", a_moving, 0);
    chk("rev_idle_pos", a_position, 8);
    tick(1);
    chk("rev_falling", a_moving, 1);
    tick(15);
    chk("rev_pos1", a_position, 1);
    tick(1);
    chk("rev_pos0", a_position, 0);
    chk("rev_dn_limit", a_dn_limit, 1);
    chk("rev_stop", a_moving, 0);
    motor_dn = 1'b0;

    // Async reset mid-step at 9
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    motor_up = 1'b1;
    tick(19);
    chk("ar_pos9", a_position, 9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_pos", a_position, 0);
    chk("ar_moving", a_moving, 0);
    chk("ar_fault", a_fault, 0);
    chk("ar_dn_limit", a_dn_limit, 1);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("ar_rel_pos", a_position, 0);
    chk("ar_rel_moving", a_moving, 1);
    tick(1);
    chk("ar_rel_pos1", a_position, 0);
    motor_up = 1'b0;

    // STEP_DIV=3: partial count discarded
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    motor_up = 1'b1;
    tick(8);
    chk("sd3_pos2", b_position, 2);
    motor_up = 1'b0;
    tick(1);
    chk("sd3_idle", b_moving, 0);
    chk("sd3_hold", b_position, 2);
    motor_up = 1'b1;
    tick(3);
    chk("sd3_partial", b_position, 2);
    tick(1);
    chk("sd3_pos3", b_position, 3);
    motor_up = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
